// File: rtl/uart_autobaud_if.sv
// Handshake bundle between the UART control logic (master) and the autobaud
// measurement block (slave): arm pulse, synchronized RX line and the result.
interface uart_autobaud_if;
  logic        i_start;
  logic        i_rx;
  logic [15:0] o_scaler;
  logic        o_valid;
  logic        o_error;
  logic        o_busy;

  modport slave (
    input  i_start,
    input  i_rx,
    output o_scaler,
    output o_valid,
    output o_error,
    output o_busy
  );

  modport master (
    output i_start,
    output i_rx,
    input  o_scaler,
    input  o_valid,
    input  o_error,
    input  o_busy
  );
endinterface

// File: rtl/uart_autobaud.sv
// Measures the bit period of a 0x55 sync byte and returns round(N/8) as the prescaler divider.
// Optional RX majority filter: define UART_AUTOBAUD_GLITCH_FILTER_EN.
module uart_autobaud #(
  parameter logic [15:0] InitialDivider = 16'd16,
  parameter int unsigned MinScaler      = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  uart_autobaud_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HIGH,
    S_WAIT_START,
    S_MEASURE,
    S_WAIT_STOP,
    S_DONE,
    S_FAIL
  } state_e;

  localparam int unsigned     CntW   = 19;
  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic [16:0]     MinR   = 17'(MinScaler);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic [2:0]      edges_q;
  logic [15:0]     result_q;
  logic [15:0]     scaler_q;
  logic            valid_q;
  logic            error_q;
  logic            busy_q;
  logic            rx_q;
  logic            rx_s;
  logic            fall;
  logic [19:0]     n_cnt;
  logic [16:0]     r_val;
  logic            r_bad;
  logic [CntW-1:0] stop_limit;

`ifdef UART_AUTOBAUD_GLITCH_FILTER_EN
  // Majority of the last three samples: a single-cycle pulse never wins, and
  // both edges come out two cycles late, so the measured span is unchanged.
  logic [2:0] filt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      filt_q <= 3'b111;
    end else begin
      filt_q <= {filt_q[1:0], bus.i_rx};
    end
  end

  assign rx_s = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) | (filt_q[1] & filt_q[2]);
`else
  assign rx_s = bus.i_rx;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_q <= 1'b1;
    end else begin
      rx_q <= rx_s;
    end
  end

  assign fall       = rx_q & ~rx_s;
  assign cnt_d      = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
  // N counts the cycles from edge-1 detection to edge-5 detection.
  assign n_cnt      = {1'b0, cnt_q} + 20'd1;
  assign r_val      = 17'((n_cnt + 20'd4) >> 3);
  assign r_bad      = r_val[16] | (r_val < MinR);
  assign stop_limit = {2'b00, result_q, 1'b0};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      edges_q  <= '0;
      // NOTE: the result register is reset as well, so a stale value from a
      // previous run can never be loaded into o_scaler after a reset.
      result_q <= InitialDivider;
      scaler_q <= InitialDivider;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the pulse defaults below are
      // overridden later in the same block only in DONE/FAIL.
      valid_q <= 1'b0;
      error_q <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            state_q <= S_WAIT_HIGH;
            busy_q  <= 1'b1;
          end
        end

        S_WAIT_HIGH: begin
          if (rx_s) begin
            state_q <= S_WAIT_START;
          end
        end

        S_WAIT_START: begin
          if (fall) begin
            cnt_q   <= '0;
            edges_q <= 3'd1;
            state_q <= S_MEASURE;
          end
        end

        S_MEASURE: begin
          cnt_q <= cnt_d;
          if (fall) begin
            edges_q <= edges_q + 3'd1;
          end
          if (fall && (edges_q == 3'd4)) begin
            if (r_bad) begin
              state_q <= S_FAIL;
            end else begin
              result_q <= r_val[15:0];
              cnt_q    <= '0;
              state_q  <= S_WAIT_STOP;
            end
          end else if (cnt_q == CntMax) begin
            state_q <= S_FAIL;
          end
        end

        S_WAIT_STOP: begin
          // Data bit 7 is low; the stop bit must rise within two bit periods.
          cnt_q <= cnt_d;
          if (rx_s) begin
            state_q <= S_DONE;
          end else if (cnt_q == stop_limit) begin
            state_q <= S_FAIL;
          end
        end

        S_DONE: begin
          scaler_q <= result_q;
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end

        S_FAIL: begin
          error_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_scaler = scaler_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_error  = error_q;
  assign bus.o_busy   = busy_q;

endmodule
